// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the shift_reg SIPO receiver.
// The receiver's optional parity stage is enabled by the SIPO_PARITY_EN macro.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } sipo_state_e;

  // Bit count must be able to hold WIDTH, which is the value it rests at in PAR.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready output buffer for the SIPO receiver, with a sticky
// overflow flag for words that arrive while the buffer is still full.
module sipo_out_buf
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             word_valid,
  input  logic [WIDTH-1:0] word_data,
  input  logic             word_perr,
  input  logic             out_ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overflow,
  output logic             parity_err
);

  logic xfer;
  logic drop;

  assign xfer = out_valid && out_ready;
  // A completing word is lost only when the buffer is full and not draining.
  assign drop = word_valid && out_valid && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (word_valid && !drop) begin
        out_data   <= word_data;
        parity_err <= word_perr;
        out_valid  <= 1'b1;
      end else if (xfer) begin
        out_valid  <= 1'b0;
      end

      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/shift_reg_sipo_rx.sv
// Serial-in/parallel-out receiver: MSB-first bit assembly into WIDTH-bit words.
// Define SIPO_PARITY_EN to add a trailing even-parity bit per word.
module shift_reg_sipo_rx
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             parity_err
);

  localparam int CW = cnt_width(WIDTH);
`ifdef SIPO_PARITY_EN
  localparam int SW = WIDTH;
`else
  // Without parity the top bit is never read back; it goes straight to out_data.
  localparam int SW = WIDTH - 1;
`endif

  sipo_state_e      state;
  logic [SW-1:0]    shreg;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;
  logic             word_valid;
  logic [WIDTH-1:0] word_data;
  logic             word_perr;

  assign shifted  = {shreg[WIDTH-2:0], serial_in};
  assign last_bit = bit_valid && !sync_clr && (state != PAR) && (count == CW'(WIDTH - 1));

`ifdef SIPO_PARITY_EN
  assign word_valid = bit_valid && !sync_clr && (state == PAR);
  assign word_data  = shreg;
  assign word_perr  = ^{shreg, serial_in};
`else
  assign word_valid = last_bit;
  assign word_data  = shifted;
  assign word_perr  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
    end else if (sync_clr) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
    end else if (bit_valid) begin
      case (state)
        IDLE, SHIFT: begin
          shreg <= shifted[SW-1:0];
          if (last_bit) begin
`ifdef SIPO_PARITY_EN
            state <= PAR;
            count <= CW'(WIDTH);
`else
            state <= IDLE;
            count <= '0;
`endif
          end else begin
            state <= SHIFT;
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_perr  (word_perr),
    .out_ready  (out_ready),
    .ovf_clr    (ovf_clr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

endmodule

// File: doc/shift_reg_sipo_rx.md
Name: shift_reg_sipo_rx

Overview:
Serial-in/parallel-out receiver, the receive end of the shift_reg_piso link. It samples a serial bit stream, MSB first, on per-bit strobes and assembles WIDTH-bit words. Each completed word goes into a one-entry output buffer with a valid/ready handshake. It sits between a serial line (or a PISO transmitter) and a parallel consumer, and flags overflow when backpressure causes a word to be lost.

Parameters:
WIDTH, 8, data word width in bits (legal range 2..32)

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
serial_in  input  1  serial data bit, MSB of each word first
bit_valid  input  1  serial_in is sampled on this cycle's posedge
sync_clr  input  1  synchronous framing resync; discards the partial word
out_data  output  WIDTH  assembled word held in the output buffer
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts out_data when out_valid && out_ready
busy  output  1  partial word in progress (bit count != 0)
overflow  output  1  sticky flag: a completed word was dropped
ovf_clr  input  1  synchronous clear of overflow
parity_err  output  1  parity result for out_data (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous): shift register, bit count, out_data, out_valid, overflow and parity_err all go to 0; FSM goes to IDLE.
- FSM states:
  - IDLE (count 0): first bit_valid moves to SHIFT.
  - SHIFT (count 1..WIDTH-1): the bit_valid that samples the last data bit completes the word and returns to IDLE (or goes to PAR when parity is enabled).
- Shift rule: on bit_valid, shreg <= {shreg[WIDTH-2:0], serial_in} and count increments. With bit_valid=0, the shift register and count hold.
- Word completion:
  - On the edge sampling the final bit, the full word {shreg[WIDTH-2:0], serial_in} is written to out_data.
  - out_valid is 1 from the next cycle. Latency is 0 cycles after the sampling edge; the word is visible immediately after that edge.
- Handshake:
  - A transfer occurs on an edge with out_valid && out_ready.
  - out_valid clears on the transfer edge unless a new word completes on that same edge. In that case the new word loads and out_valid stays 1, which gives full throughput.
  - out_data is stable while out_valid=1 and no transfer occurs.
- Overflow:
  - Word completes while out_valid=1 and out_ready=0: the new word is dropped, the buffer keeps the old word, and overflow is set.
  - overflow stays set until ovf_clr. If set and ovf_clr occur on the same edge, set wins.
- sync_clr: clears the shift register and count and returns the FSM to IDLE. sync_clr=1 together with bit_valid=1 means clear wins and the bit is discarded. The output buffer, out_valid and overflow are unaffected.
- busy = (FSM != IDLE).
- Reset mid-word or mid-handshake: everything clears and any buffered word is lost.
- No combinational path from out_ready to out_valid or out_data.

Optional Feature:
Macro SIPO_PARITY_EN.
- Defined:
  - FSM gains a PAR state entered after WIDTH data bits.
  - The next bit_valid samples an even-parity bit. The word is delivered on that edge (one extra bit period of latency).
  - parity_err = XOR of the WIDTH data bits and the parity bit, captured with out_data and held with it.
  - sync_clr in PAR discards the word.
- Undefined: no PAR state, and parity_err is tied to 0.

Decomposition:
- Package shift_reg_pkg holds:
  - typedef enum logic [1:0] sipo_state_e {IDLE, SHIFT, PAR};
  - localparam function for the count width, $clog2(WIDTH+1).
- One natural sub-module, sipo_out_buf: the one-entry valid/ready buffer plus overflow logic. The top level keeps the FSM and shift register.

Test Plan:
- Basic word: bits 1,0,1,0,0,1,0,1 on 8 consecutive bit_valid edges, out_ready=0 → out_data=0xA5 and out_valid=1 right after the 8th edge; busy=0.
- Back-to-back: 0xA5 then 0x3C with no gaps, out_ready=1 → two transfers, out_valid continuous across the second word's completion, and no overflow.
- Backpressure: send 0xF0, hold out_ready=0, send 0x0F → out_data stays 0xF0 and overflow=1. Then pulse ovf_clr → overflow=0.
- Resync: send 3 bits, assert sync_clr together with a 4th bit_valid, then send 0x81 → out_data=0x81; the discarded bits are absent.
- Gapped strobes and reset: 0xC3 with bit_valid every 3rd cycle → correct word. Then assert rst_n=0 after 5 bits of the next word → all outputs 0, and a following 0x55 is received correctly.
- Parity (SIPO_PARITY_EN): 0xA5 + parity bit 0 → parity_err=0. 0xA5 + parity bit 1 → parity_err=1. Delivery is one strobe later than without parity.
